pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Soft-start/soft-stop controller that drives the enable and duty inputs of the PWM core. It accepts target duty commands over a valid/ready handshake. It ramps the applied duty toward the target in fixed steps, and applies duty changes only at PWM period boundaries so no period is glitched. It also performs a period-aligned shutdown by ramping duty to 0 before deasserting enable.

Parameters:
WIDTH, 8, duty/period-counter resolution; must match the driven PWM core.
STEP, 1, duty increment/decrement per ramp step; range 1..2^WIDTH-1.
PERIODS_PER_STEP, 4, number of full PWM periods between ramp steps; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  pulse that begins PWM operation from IDLE.
stop  input  1  pulse that begins a controlled ramp-down to off.
cmd_valid  input  1  target duty command valid.
cmd_duty  input  WIDTH  requested target duty.
cmd_ready  output  1  command can be accepted; equals (state != STOPPING).
pwm_enable  output  1  drives the core enable input; registered.
pwm_duty  output  WIDTH  drives the core duty input; registered.
period_tick  output  1  high in the last cycle of each PWM period.
at_target  output  1  state==RUN and pwm_duty==target.
busy  output  1  state != IDLE.

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - rst is asynchronous and active-high.
  - On rst: state=IDLE, pwm_enable=0, pwm_duty=0, target=0, period_cnt=0, step_cnt=0.
  - Resulting outputs: cmd_ready=1, period_tick=0, at_target=0, busy=0.
- Period tracking:
  - Internal period_cnt (WIDTH bits) mirrors the core counter.
  - It is forced to 0 while pwm_enable=0; otherwise it increments every cycle and wraps at 2^WIDTH-1 -> 0.
  - period_tick = pwm_enable && period_cnt==2^WIDTH-1, decoded combinationally from registers.
  - pwm_enable rising edge marks cycle 0 of the first period.
- Duty update rule: while pwm_enable=1, pwm_duty changes only on the clock edge where period_tick=1, so the new duty applies from counter 0.
- Step scheduler:
  - step_cnt counts period_ticks 0..PERIODS_PER_STEP-1 and wraps.
  - On a tick with step_cnt==PERIODS_PER_STEP-1 and pwm_duty!=target, one step is taken.
  - Up step: pwm_duty = min(pwm_duty+STEP, target), summed in WIDTH+1 bits, never wraps.
  - Down step: pwm_duty = (pwm_duty-target > STEP) ? pwm_duty-STEP : target, never underflows.
  - step_cnt holds at 0 while pwm_duty==target.
- Commands:
  - Accepted when cmd_valid && cmd_ready; target <= cmd_duty on that edge.
  - A step decision on the same edge uses the old target.
  - Accepting a command does not reset step_cnt.
- FSM states:
  - IDLE: pwm_enable=0, pwm_duty=0; commands are accepted.
    - start && !stop -> RUN; pwm_enable=1 from the next cycle; duty starts at 0.
    - start && stop on the same cycle: stop wins, stay in IDLE.
    - stop alone: no effect.
  - RUN: ramps toward target per the step scheduler; start is ignored.
    - stop -> STOPPING; target <= 0.
    - A command and stop on the same cycle: stop wins and the command is dropped; cmd_ready is still 1 that cycle, so the requester sees a handshake but the command has no effect.
  - STOPPING: cmd_ready=0; start and stop are ignored; ramps down to 0 using the same step rules.
    - On a period_tick with pwm_duty==0 -> IDLE; pwm_enable=0 and period_cnt=0 from the next cycle.
    - A shutdown always completes a whole period at duty 0 before disable.
    - STOPPING entered with pwm_duty==0 exits at the next period_tick.
- Target 0 in RUN: pwm_enable stays 1 with duty 0 (output held low, counter running); at_target=1.
- rst asserted mid-ramp or mid-stop: immediate return to reset values. pwm_enable drops asynchronously, forcing the core output low.

Test Plan:
- All tests use WIDTH=4 (period = 16 cycles), STEP=3, PERIODS_PER_STEP=2.
- Reset: assert rst mid-cycle -> pwm_enable=0, pwm_duty=0, busy=0, cmd_ready=1 immediately, without waiting for a clk edge.
- Ramp up with clamp: in IDLE send cmd_duty=10, then pulse start -> pwm_enable=1 from the next cycle. pwm_duty steps 0->3->6->9->10, each change 32 cycles apart and only on the edge after period_tick. at_target=1 once duty=10.
- Ramp down: at duty 10 send cmd_duty=2 -> duty 10->7->4->2 on step boundaries, then holds; at_target=1.
- Controlled stop: at duty 9 pulse stop -> cmd_ready=0 and busy=1; duty 9->6->3->0. One more full period at duty 0, then pwm_enable=0 and busy=0 on the edge after that period_tick. A cmd_valid presented during STOPPING is not accepted.
- Simultaneous events:
  - start+stop together in IDLE -> stays IDLE.
  - cmd_valid=1 with cmd_duty=12 on the edge of a scheduled up-step from 3 toward target 6 -> the step gives duty 6 (old target); later steps proceed to 9, 12.
- Reset mid-operation: assert rst during a ramp at duty 6 -> outputs return to reset values. After release, start with target 0 -> RUN, pwm_duty stays 0, at_target=1, and period_tick pulses every 16 cycles.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop ramp controller for a PWM core.
// Duty moves toward a commanded target only at period boundaries.
module pwm_ramp_ctrl #(
  parameter int WIDTH            = 8,
  parameter int STEP             = 1,
  parameter int PERIODS_PER_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cmd_valid,
  input  logic [WIDTH-1:0] cmd_duty,
  output logic             cmd_ready,
  output logic             pwm_enable,
  output logic [WIDTH-1:0] pwm_duty,
  output logic             period_tick,
  output logic             at_target,
  output logic             busy
);

  localparam int SCW =
    (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [SCW-1:0]   STEP_LAST = SCW'(PERIODS_PER_STEP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_t;

  state_t           r_state;
  logic             r_enable;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_period_cnt;
  logic [SCW-1:0]   r_step_cnt;

  logic             w_tick;
  logic [WIDTH:0]   w_up_sum;
  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_dn;
  logic [WIDTH-1:0] w_next_duty;

  assign w_tick = r_enable && (r_period_cnt == CNT_MAX);

  // Up steps saturate at target; extra bit keeps the sum from wrapping.
  assign w_up_sum = {1'b0, r_duty} + STEP_X;
  assign w_up = (w_up_sum > {1'b0, r_target}) ?
                r_target : w_up_sum[WIDTH-1:0];

  assign w_diff = r_duty - r_target;
  assign w_dn = ({1'b0, w_diff} > STEP_X) ?
                r_duty - STEP_X[WIDTH-1:0] : r_target;

  assign w_next_duty = (r_duty < r_target) ? w_up : w_dn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_enable     <= 1'b0;
      r_duty       <= '0;
      r_target     <= '0;
      r_period_cnt <= '0;
      r_step_cnt   <= '0;
    end else begin
      r_period_cnt <= r_enable ? r_period_cnt + WIDTH'(1) : '0;

      if (w_tick) begin
        if (r_duty == r_target) begin
          r_step_cnt <= '0;
        end else if (r_step_cnt == STEP_LAST) begin
          r_step_cnt <= '0;
          r_duty     <= w_next_duty;
        end else begin
          r_step_cnt <= r_step_cnt + SCW'(1);
        end
      end

      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) r_target <= cmd_duty;
          if (start && !stop) begin
            r_state  <= S_RUN;
            r_enable <= 1'b1;
          end
        end
        S_RUN: begin
          // Stop drops any command presented on the same edge.
          if (stop) begin
            r_state  <= S_STOP;
            r_target <= '0;
          end else if (cmd_valid) begin
            r_target <= cmd_duty;
          end
        end
        S_STOP: begin
          if (w_tick && r_duty == '0) begin
            r_state    <= S_IDLE;
            r_enable   <= 1'b0;
            r_step_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (r_state != S_STOP);
  assign pwm_enable  = r_enable;
  assign pwm_duty    = r_duty;
  assign period_tick = w_tick;
  assign at_target   = (r_state == S_RUN) && (r_duty == r_target);
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: cycle-level behavioural model plus
// directed scenarios with hand-computed timing and duty values.
module tb_pwm_ramp_ctrl;

  localparam int W      = 4;
  localparam int STEP   = 3;
  localparam int PPS    = 2;
  localparam int PERIOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         cmd_valid;
  logic [W-1:0] cmd_duty;
  logic         cmd_ready;
  logic         pwm_enable;
  logic [W-1:0] pwm_duty;
  logic         period_tick;
  logic         at_target;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_ramp_ctrl #(
    .WIDTH(W),
    .STEP(STEP),
    .PERIODS_PER_STEP(PPS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .cmd_valid(cmd_valid),
    .cmd_duty(cmd_duty),
    .cmd_ready(cmd_ready),
    .pwm_enable(pwm_enable),
    .pwm_duty(pwm_duty),
    .period_tick(period_tick),
    .at_target(at_target),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: mode 0=idle 1=run 2=stopping; position within period;
  // count of boundaries seen since the last step.
  int m_mode  = 0;
  bit m_en    = 1'b0;
  int m_duty  = 0;
  int m_tgt   = 0;
  int m_pos   = 0;
  int m_ticks = 0;

  always @(posedge clk or posedge rst) begin
    int  nd, nt, nm, np, nk;
    bit  ne, tick;
    if (rst) begin
      m_mode  <= 0;
      m_en    <= 1'b0;
      m_duty  <= 0;
      m_tgt   <= 0;
      m_pos   <= 0;
      m_ticks <= 0;
    end else begin
      nd = m_duty; nt = m_tgt; nm = m_mode; nk = m_ticks; ne = m_en;
      tick = m_en && (m_pos == PERIOD - 1);
      np = m_en ? (m_pos + 1) % PERIOD : 0;
      if (tick) begin
        if (m_duty == m_tgt) nk = 0;
        else if (m_ticks + 1 == PPS) begin
          nk = 0;
          if (m_duty < m_tgt)
            nd = (m_duty + STEP < m_tgt) ? m_duty + STEP : m_tgt;
          else
            nd = (m_duty - STEP > m_tgt) ? m_duty - STEP : m_tgt;
        end else nk = m_ticks + 1;
      end
      case (m_mode)
        0: begin
          if (cmd_valid) nt = int'(cmd_duty);
          if (start && !stop) begin nm = 1; ne = 1'b1; end
        end
        1: begin
          if (stop) begin nm = 2; nt = 0; end
          else if (cmd_valid) nt = int'(cmd_duty);
        end
        default: begin
          if (tick && m_duty == 0) begin
            nm = 0; ne = 1'b0; nd = 0; nk = 0;
          end
        end
      endcase
      m_duty  <= nd;
      m_tgt   <= nt;
      m_mode  <= nm;
      m_en    <= ne;
      m_pos   <= np;
      m_ticks <= nk;
    end
  end

  always @(negedge clk) begin
    bit e_tick, e_rdy, e_at, e_busy;
    e_tick = m_en && (m_pos == PERIOD - 1);
    e_rdy  = (m_mode != 2);
    e_at   = (m_mode == 1) && (m_duty == m_tgt);
    e_busy = (m_mode != 0);
    n_checks++;
    if (pwm_enable !== m_en || int'(pwm_duty) != m_duty ||
        period_tick !== e_tick || cmd_ready !== e_rdy ||
        at_target !== e_at || busy !== e_busy) begin
      n_fail++;
      $display("FAIL model t=%0t got en=%b duty=%0d tick=%b rdy=%b at=%b busy=%b exp en=%b duty=%0d tick=%b rdy=%b at=%b busy=%b",
               $time, pwm_enable, pwm_duty, period_tick, cmd_ready,
               at_target, busy, m_en, m_duty, e_tick, e_rdy, e_at,
               e_busy);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_duty(input int val, output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (int'(pwm_duty) == val) break;
    end
    chk($sformatf("reach_duty_%0d", val), int'(pwm_duty), val);
  endtask

  task automatic pulse_cmd(input int d);
    cmd_valid = 1'b1;
    cmd_duty  = W'(d);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, nt, first;
    start = 0; stop = 0; cmd_valid = 0; cmd_duty = '0; rst = 0;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_en", int'(pwm_enable), 0);
    chk("rst_duty", int'(pwm_duty), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_at", int'(at_target), 0);
    rst = 0;
    @(negedge clk);

    // Ramp up 0->3->6->9->10, one step every 32 cycles
    pulse_cmd(10);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_en", int'(pwm_enable), 1);
    chk("start_duty", int'(pwm_duty), 0);
    wait_duty(3, n);  chk("up3_gap", n, 32);
    wait_duty(6, n);  chk("up6_gap", n, 32);
    wait_duty(9, n);  chk("up9_gap", n, 32);
    wait_duty(10, n); chk("up10_gap", n, 32);
    chk("up_at", int'(at_target), 1);

    // Ramp down 10->7->4->2 and hold
    pulse_cmd(2);
    wait_duty(7, n); chk("dn7_gap", n, 31);
    wait_duty(4, n); chk("dn4_gap", n, 32);
    wait_duty(2, n); chk("dn2_gap", n, 32);
    chk("dn_at", int'(at_target), 1);
    repeat (64) @(negedge clk);
    chk("dn_hold", int'(pwm_duty), 2);

    // Controlled stop from 9
    pulse_cmd(9);
    wait_duty(5, n);
    wait_duty(8, n);
    wait_duty(9, n);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("stop_ready", int'(cmd_ready), 0);
    chk("stop_busy", int'(busy), 1);
    wait_duty(6, n); chk("st6_gap", n, 31);
    cmd_valid = 1; cmd_duty = 4'd12;
    repeat (4) @(negedge clk);
    chk("stop_cmd_ready", int'(cmd_ready), 0);
    cmd_valid = 0;
    wait_duty(3, n);
    wait_duty(0, n);
    n = 0;
    while (n < 40 && pwm_enable) begin @(negedge clk); n++; end
    chk("off_gap", n, 16);
    chk("off_busy", int'(busy), 0);
    chk("off_ready", int'(cmd_ready), 1);

    // start and stop together in IDLE
    start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    repeat (3) @(negedge clk);
    chk("ss_busy", int'(busy), 0);
    chk("ss_en", int'(pwm_enable), 0);

    // Command landing on the edge of a scheduled step
    pulse_cmd(6);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_duty(3, n); chk("col3_gap", n, 32);
    repeat (31) @(negedge clk);
    chk("col_tick", int'(period_tick), 1);
    cmd_valid = 1; cmd_duty = 4'd12;
    @(negedge clk);
    cmd_valid = 0;
    chk("col_old_tgt", int'(pwm_duty), 6);
    wait_duty(9, n);  chk("col9_gap", n, 32);
    wait_duty(12, n); chk("col12_gap", n, 32);

    // Asynchronous reset mid-ramp at duty 6
    pulse_cmd(0);
    wait_duty(9, n);
    wait_duty(6, n);
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_en", int'(pwm_enable), 0);
    chk("arst_duty", int'(pwm_duty), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Run with target 0
    start = 1;
    @(negedge clk);
    start = 0;
    nt = 0; first = -1;
    for (int i = 0; i < 64; i++) begin
      if (period_tick) begin
        if (first < 0) first = i;
        nt++;
      end
      @(negedge clk);
    end
    chk("z_first_tick", first, 15);
    chk("z_ticks", nt, 4);
    chk("z_duty", int'(pwm_duty), 0);
    chk("z_at", int'(at_target), 1);
    chk("z_en", int'(pwm_enable), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
